// File: rtl/loopback_test_seq.sv
// Pin-loopback test sequencer: walks a one-hot drive pattern across the jig
// outputs, checks the synchronized loopback inputs and reports a fail mask.
module loopback_test_seq #(
  parameter int NUM_CHAN      = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic [NUM_CHAN-1:0]         tx,
  input  logic [NUM_CHAN-1:0]         rx,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [NUM_CHAN-1:0]         fail_mask,
  output logic [$clog2(NUM_CHAN)-1:0] first_fail,
  output logic                        result_valid
);

  localparam int CHW  = $clog2(NUM_CHAN);
  localparam int CNTW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNTW-1:0]     CNT_LAST  = CNTW'(SETTLE_CYCLES - 1);
  localparam logic [CHW-1:0]      CHAN_LAST = CHW'(NUM_CHAN - 1);
  localparam logic [NUM_CHAN-1:0] ONE       = NUM_CHAN'(1);

  // Two synchronizer stages plus the registered tx give three cycles of lag.
  if (SETTLE_CYCLES < 3) begin : g_bad_settle
    $error("loopback_test_seq: SETTLE_CYCLES must be >= 3");
  end
  if (NUM_CHAN < 2 || NUM_CHAN > 32) begin : g_bad_chan
    $error("loopback_test_seq: NUM_CHAN must be in 2..32");
  end

  typedef enum logic [2:0] {
    IDLE,
    SETTLE_LOW,
    CHECK_LOW,
    SETTLE_HIGH,
    CHECK_HIGH,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CHW-1:0]      chan_q, chan_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                found_q, found_d;
  logic [NUM_CHAN-1:0] sync1_q, sync1_d;
  logic [NUM_CHAN-1:0] rx_s_q, rx_s_d;
  logic [NUM_CHAN-1:0] tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [NUM_CHAN-1:0] fail_mask_q, fail_mask_d;
  logic [CHW-1:0]      first_fail_q, first_fail_d;
  logic                result_valid_q, result_valid_d;
  logic [NUM_CHAN-1:0] mismatch;
  logic                check;

  always_comb begin
    state_d        = state_q;
    chan_d         = chan_q;
    cnt_d          = cnt_q;
    found_d        = found_q;
    sync1_d        = rx;
    rx_s_d         = sync1_q;
    pass_d         = pass_q;
    fail_mask_d    = fail_mask_q;
    first_fail_d   = first_fail_q;
    result_valid_d = result_valid_q;
    mismatch       = '0;
    check          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d        = SETTLE_LOW;
          chan_d         = '0;
          cnt_d          = '0;
          found_d        = 1'b0;
          pass_d         = 1'b0;
          fail_mask_d    = '0;
          first_fail_d   = '0;
          result_valid_d = 1'b0;
        end
      end
      SETTLE_LOW: begin
        if (cnt_q == CNT_LAST) state_d = CHECK_LOW;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      CHECK_LOW: begin
        mismatch = rx_s_q;
        check    = 1'b1;
        cnt_d    = '0;
        state_d  = SETTLE_HIGH;
      end
      SETTLE_HIGH: begin
        if (cnt_q == CNT_LAST) state_d = CHECK_HIGH;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      CHECK_HIGH: begin
        mismatch = rx_s_q ^ (ONE << chan_q);
        check    = 1'b1;
        cnt_d    = '0;
        if (chan_q == CHAN_LAST) begin
          state_d = DONE;
        end else begin
          chan_d  = chan_q + 1'b1;
          state_d = SETTLE_LOW;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Any mismatching bit implicates that channel; only the first failing check names first_fail.
    if (check) begin
      fail_mask_d = fail_mask_q | mismatch;
      if (mismatch != '0 && !found_q) begin
        found_d      = 1'b1;
        first_fail_d = chan_q;
      end
    end

    // Outputs are decoded from the next state so they are registered yet cycle-aligned with it.
    tx_d   = (state_d == SETTLE_HIGH || state_d == CHECK_HIGH) ? (ONE << chan_d) : '0;
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
    if (state_d == DONE) begin
      pass_d         = (fail_mask_d == '0);
      result_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      chan_q         <= '0;
      cnt_q          <= '0;
      found_q        <= 1'b0;
      sync1_q        <= '0;
      rx_s_q         <= '0;
      tx_q           <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      fail_mask_q    <= '0;
      first_fail_q   <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      chan_q         <= chan_d;
      cnt_q          <= cnt_d;
      found_q        <= found_d;
      sync1_q        <= sync1_d;
      rx_s_q         <= rx_s_d;
      tx_q           <= tx_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      fail_mask_q    <= fail_mask_d;
      first_fail_q   <= first_fail_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign tx           = tx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail_mask    = fail_mask_q;
  assign first_fail   = first_fail_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_loopback_test_seq.sv
// Bench for loopback_test_seq: fault-injecting loopback model, scoreboard queue
// filled by the stimulus and drained by an independent done-driven monitor.
module tb_loopback_test_seq;

  localparam int NC      = 8;
  localparam int SC      = 4;
  localparam int RUN_LEN = NC * 2 * (SC + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [NC-1:0] tx, rx, fail_mask;
  logic busy, done, pass, result_valid;
  logic [2:0] first_fail;

  logic [7:0] f_sl  = 8'h00;
  logic [7:0] f_sh  = 8'h00;
  logic       f_sen = 1'b0;
  logic [2:0] f_a   = 3'd0;
  logic [2:0] f_b   = 3'd0;

  int cyc    = 0;
  int n_vec  = 0;
  int n_fail = 0;
  int n_done = 0;

  typedef struct {
    logic [7:0] mask;
    logic [2:0] ff;
    logic       pass;
    int         done_cyc;
  } exp_t;

  exp_t sb[$];

  loopback_test_seq #(.NUM_CHAN(NC), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .start(start), .tx(tx), .rx(rx), .busy(busy),
    .done(done), .pass(pass), .fail_mask(fail_mask), .first_fail(first_fail),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Jig wiring with optional short between two channels, then stuck-low / stuck-high bits.
  function automatic logic [7:0] faultFn(input logic [7:0] t, input logic [7:0] sl,
                                         input logic [7:0] sh, input logic sen,
                                         input logic [2:0] a, input logic [2:0] b);
    logic [7:0] r;
    logic       x;
    r = t;
    x = t[a] | t[b];
    if (sen) begin
      r[a] = x;
      r[b] = x;
    end
    return (r & ~sl) | sh;
  endfunction

  assign rx = faultFn(tx, f_sl, f_sh, f_sen, f_a, f_b);

  // Every channel gets an all-low check then a one-hot check; any deviation implicates the bit.
  function automatic exp_t refModel();
    exp_t       e;
    logic [7:0] drive, seen;
    bit         found;
    found  = 0;
    e.mask = 8'h00;
    e.ff   = 3'd0;
    for (int c = 0; c < NC; c++) begin
      for (int ph = 0; ph < 2; ph++) begin
        drive  = (ph == 0) ? 8'h00 : (8'h01 << c);
        seen   = faultFn(drive, f_sl, f_sh, f_sen, f_a, f_b) ^ drive;
        e.mask = e.mask | seen;
        if (seen != 8'h00 && !found) begin
          found = 1;
          e.ff  = c[2:0];
        end
      end
    end
    e.pass     = (e.mask == 8'h00);
    e.done_cyc = 0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic setFault(input logic [7:0] sl, input logic [7:0] sh, input logic sen,
                          input logic [2:0] a, input logic [2:0] b);
    f_sl  = sl;
    f_sh  = sh;
    f_sen = sen;
    f_a   = a;
    f_b   = b;
  endtask

  task automatic startPulse(output int n);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = cyc;
  endtask

  task automatic applyStimulus(input bit hand, input logic [7:0] hmask, input logic [2:0] hff);
    exp_t e;
    int   n;
    if (hand) begin
      e.mask = hmask;
      e.ff   = hff;
      e.pass = (hmask == 8'h00);
    end else begin
      e = refModel();
    end
    startPulse(n);
    e.done_cyc = n + RUN_LEN;
    sb.push_back(e);
  endtask

  task automatic waitDrain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  // Monitor: tx shape checks every cycle, scoreboard pop on each done pulse.
  int         busy_run = 0;
  int         hi_len   = 0;
  logic [7:0] prev_tx  = 8'h00;
  logic [7:0] walk[$];
  exp_t       mon_e;

  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
      hi_len   = 0;
      prev_tx  = 8'h00;
      walk.delete();
    end else begin
      if (busy) busy_run++;
      else checkOutput("tx_zero_when_not_busy", tx, 0);
      if (tx != 8'h00) begin
        if (prev_tx == 8'h00) begin
          walk.push_back(tx);
          hi_len = 1;
        end else begin
          hi_len++;
        end
      end else if (prev_tx != 8'h00) begin
        checkOutput("tx_high_len", hi_len, SC + 1);
      end
      prev_tx = tx;
      if (done) begin
        n_done++;
        if (sb.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("[TB] FAIL unexpected_done: done=1 at cycle %0d, expected no done", cyc);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("done_cycle", cyc, mon_e.done_cyc);
          checkOutput("pass", pass, mon_e.pass);
          checkOutput("fail_mask", fail_mask, mon_e.mask);
          checkOutput("first_fail", first_fail, mon_e.ff);
          checkOutput("result_valid_at_done", result_valid, 1);
          checkOutput("busy_cycles", busy_run, RUN_LEN);
          checkOutput("walk_count", walk.size(), NC);
          for (int i = 0; i < walk.size() && i < NC; i++)
            checkOutput("walk_tx", walk[i], 32'h1 << i);
        end
        busy_run = 0;
        walk.delete();
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   n, d0;
    exp_t e1, e2;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_tx", tx, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_pass", pass, 0);
    checkOutput("reset_fail_mask", fail_mask, 0);
    checkOutput("reset_first_fail", first_fail, 0);
    checkOutput("reset_result_valid", result_valid, 0);
    rst = 1'b0;

    $display("[TB] ideal loopback");
    setFault(8'h00, 8'h00, 1'b0, 3'd0, 3'd0);
    applyStimulus(1, 8'h00, 3'd0);
    waitDrain();
    repeat (3) begin
      checkOutput("result_valid_hold", result_valid, 1);
      checkOutput("pass_hold", pass, 1);
      @(posedge clk); #1;
    end

    $display("[TB] rx[3] stuck low");
    setFault(8'h08, 8'h00, 1'b0, 3'd0, 3'd0);
    applyStimulus(1, 8'h08, 3'd3);
    waitDrain();

    $display("[TB] rx[5] stuck high");
    setFault(8'h00, 8'h20, 1'b0, 3'd0, 3'd0);
    applyStimulus(1, 8'h20, 3'd0);
    waitDrain();

    $display("[TB] short ch1/ch2");
    setFault(8'h00, 8'h00, 1'b1, 3'd1, 3'd2);
    applyStimulus(1, 8'h06, 3'd1);
    waitDrain();

    $display("[TB] start re-pulsed mid-run is ignored");
    setFault(8'h40, 8'h00, 1'b0, 3'd0, 3'd0);
    applyStimulus(1, 8'h40, 3'd6);
    repeat (19) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDrain();

    $display("[TB] reset mid-sequence");
    setFault(8'h00, 8'h20, 1'b0, 3'd0, 3'd0);
    startPulse(n);
    repeat (20) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    checkOutput("busy_before_reset", busy, 1);
    checkOutput("fail_mask_before_reset", fail_mask, 8'h20);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_tx", tx, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_fail_mask", fail_mask, 0);
    checkOutput("abort_result_valid", result_valid, 0);
    rst = 1'b0;
    d0 = n_done;
    repeat (100) @(posedge clk);
    #1;
    checkOutput("no_done_after_abort", n_done, d0);

    $display("[TB] start held high across two sequences");
    setFault(8'h00, 8'h00, 1'b0, 3'd0, 3'd0);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    n = cyc;
    e1.mask = 8'h00; e1.ff = 3'd0; e1.pass = 1'b1; e1.done_cyc = n + RUN_LEN;
    e2.mask = 8'h00; e2.ff = 3'd0; e2.pass = 1'b1; e2.done_cyc = n + 2 * RUN_LEN + 2;
    sb.push_back(e1);
    sb.push_back(e2);
    repeat (RUN_LEN + 2) @(posedge clk);
    #1;
    checkOutput("restart_result_valid_cleared", result_valid, 0);
    checkOutput("restart_busy", busy, 1);
    start = 1'b0;
    waitDrain();

    $display("[TB] randomized faults");
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        setFault(8'h00, 8'h00, 1'b0, 3'd0, 3'd0);
      end else begin
        setFault(8'($urandom & $urandom & $urandom), 8'($urandom & $urandom & $urandom),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end
      applyStimulus(0, 8'h00, 3'd0);
      waitDrain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
